// File: rtl/rv_id_stage.sv
`default_nettype none
// ============================================================================
// Module  : rv_id_stage
// Purpose : RV32I decode stage with a registered ID/EX slot. It reads the
//           register file combinationally, resolves RAW hazards against NFWD
//           in-flight writers (index 0 youngest), detects load-use stalls and
//           uses a valid/ready handshake on both sides.
// Config  : ID_FWD_EN defined   -> operand forwarding, only load-use stalls.
//           ID_FWD_EN undefined -> no forwarding; any pending writer to a used
//                                  source register stalls.
// Ports   : clk, rst (sync, active-high)
//           if_valid_i/if_ready_o, pc_i, inst_i, flush_i   fetch side
//           rs1/rs2_addr_o, rs1/rs2_data_i                 register file
//           fwd_wreg_i, fwd_wd_i, fwd_wdata_i, ex_load_i   in-flight writers
//           ex_valid_o/ex_ready_i, ex_cls_o, ex_fn_o, ex_a_o, ex_b_o,
//           ex_imm_o, ex_pc_o, ex_wd_o, ex_wreg_o, ex_illegal_o  ID/EX slot
//           stall_cnt_o                                    saturating stall count
// Rev     : 1.0  initial parametrised release
// ============================================================================
module rv_id_stage #(
  parameter int XLEN = 32,
  parameter int NFWD = 2,
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [31:0]        inst_i,
  input  logic               flush_i,
  output logic [4:0]         rs1_addr_o,
  output logic [4:0]         rs2_addr_o,
  input  logic [XLEN-1:0]    rs1_data_i,
  input  logic [XLEN-1:0]    rs2_data_i,
  input  logic [NFWD-1:0]    fwd_wreg_i,
  input  logic [5*NFWD-1:0]  fwd_wd_i,
  input  logic [XLEN*NFWD-1:0] fwd_wdata_i,
  input  logic               ex_load_i,
  output logic               ex_valid_o,
  input  logic               ex_ready_i,
  output logic [2:0]         ex_cls_o,
  output logic [3:0]         ex_fn_o,
  output logic [XLEN-1:0]    ex_a_o,
  output logic [XLEN-1:0]    ex_b_o,
  output logic [XLEN-1:0]    ex_imm_o,
  output logic [XLEN-1:0]    ex_pc_o,
  output logic [4:0]         ex_wd_o,
  output logic               ex_wreg_o,
  output logic               ex_illegal_o,
  output logic [CNTW-1:0]    stall_cnt_o
);

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] c_CLS_NOP    = 3'd0;
  localparam logic [2:0] c_CLS_ALU    = 3'd1;
  localparam logic [2:0] c_CLS_LOAD   = 3'd2;
  localparam logic [2:0] c_CLS_STORE  = 3'd3;
  localparam logic [2:0] c_CLS_BRANCH = 3'd4;
  localparam logic [2:0] c_CLS_JAL    = 3'd5;
  localparam logic [2:0] c_CLS_JALR   = 3'd6;

  localparam logic [1:0] c_ASEL_ZERO  = 2'd0;
  localparam logic [1:0] c_ASEL_RS1   = 2'd1;
  localparam logic [1:0] c_ASEL_PC    = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [2:0]      cls;
    logic [3:0]      fn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      wd;
    logic            wreg;
    logic            illegal;
  } slot_t;

  // Instruction fields
  logic [6:0] w_opc;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;
  assign w_opc      = inst_i[6:0];
  assign w_rd       = inst_i[11:7];
  assign w_f3       = inst_i[14:12];
  assign w_rs1      = inst_i[19:15];
  assign w_rs2      = inst_i[24:20];
  assign rs1_addr_o = w_rs1;
  assign rs2_addr_o = w_rs2;

  // Immediates are assembled at 32 bits, then sign-extended to XLEN
  logic [31:0]     w_imm_i32, w_imm_s32, w_imm_b32, w_imm_u32, w_imm_j32;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  assign w_imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
  assign w_imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign w_imm_b32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign w_imm_u32 = {inst_i[31:12], 12'b0};
  assign w_imm_j32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign w_imm_i   = XLEN'($signed(w_imm_i32));
  assign w_imm_s   = XLEN'($signed(w_imm_s32));
  assign w_imm_b   = XLEN'($signed(w_imm_b32));
  assign w_imm_u   = XLEN'($signed(w_imm_u32));
  assign w_imm_j   = XLEN'($signed(w_imm_j32));

  // Opcode decode
  logic [2:0]      w_cls;
  logic [3:0]      w_fn;
  logic [XLEN-1:0] w_imm;
  logic [1:0]      w_asel;
  logic            w_b_rs2, w_use1, w_use2, w_wr, w_illegal;

  always_comb begin
    w_cls     = c_CLS_NOP;
    w_fn      = {1'b0, w_f3};
    w_imm     = w_imm_i;
    w_asel    = c_ASEL_ZERO;
    w_b_rs2   = 1'b0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_wr      = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      c_OPC_OP: begin
        w_cls = c_CLS_ALU; w_fn = {inst_i[30], w_f3}; w_asel = c_ASEL_RS1;
        w_b_rs2 = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_wr = 1'b1;
      end
      c_OPC_OPIMM: begin
        w_cls = c_CLS_ALU; w_asel = c_ASEL_RS1; w_use1 = 1'b1; w_wr = 1'b1;
        // only the right shifts carry the arithmetic/logical select in bit 30
        if (w_f3 == 3'b101) w_fn = {inst_i[30], w_f3};
      end
      c_OPC_LOAD: begin
        w_cls = c_CLS_LOAD; w_asel = c_ASEL_RS1; w_use1 = 1'b1; w_wr = 1'b1;
      end
      c_OPC_STORE: begin
        w_cls = c_CLS_STORE; w_imm = w_imm_s; w_asel = c_ASEL_RS1;
        w_b_rs2 = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_cls = c_CLS_BRANCH; w_imm = w_imm_b; w_asel = c_ASEL_RS1;
        w_b_rs2 = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
      end
      c_OPC_JAL: begin
        w_cls = c_CLS_JAL; w_imm = w_imm_j; w_asel = c_ASEL_PC; w_wr = 1'b1;
      end
      c_OPC_JALR: begin
        w_cls = c_CLS_JALR; w_asel = c_ASEL_RS1; w_use1 = 1'b1; w_wr = 1'b1;
      end
      c_OPC_LUI: begin
        w_cls = c_CLS_ALU; w_fn = 4'b0000; w_imm = w_imm_u; w_wr = 1'b1;
      end
      c_OPC_AUIPC: begin
        w_cls = c_CLS_ALU; w_fn = 4'b0000; w_imm = w_imm_u; w_asel = c_ASEL_PC; w_wr = 1'b1;
      end
      c_OPC_FENCE, c_OPC_SYSTEM: ;
      default: w_illegal = 1'b1;
    endcase
  end

  // Per-writer source matches; x0 never matches
  logic [4:0]      w_fwd_wd [NFWD];
  logic [NFWD-1:0] w_hit1, w_hit2;

  for (genvar k = 0; k < NFWD; k++) begin : g_match
    assign w_fwd_wd[k] = fwd_wd_i[5*k +: 5];
    assign w_hit1[k]   = fwd_wreg_i[k] & (w_fwd_wd[k] == w_rs1) & (w_rs1 != 5'd0);
    assign w_hit2[k]   = fwd_wreg_i[k] & (w_fwd_wd[k] == w_rs2) & (w_rs2 != 5'd0);
  end

  logic            w_hazard;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val;

`ifdef ID_FWD_EN
  logic [XLEN-1:0] w_fwd_data [NFWD];

  for (genvar k = 0; k < NFWD; k++) begin : g_fwd_data
    assign w_fwd_data[k] = fwd_wdata_i[XLEN*k +: XLEN];
  end

  // Only a load in the youngest slot cannot be forwarded yet
  assign w_hazard = ex_load_i & ((w_hit1[0] & w_use1) | (w_hit2[0] & w_use2));

  // Scan oldest to youngest so the lowest matching index wins
  always_comb begin
    w_rs1_val = (w_rs1 == 5'd0) ? '0 : rs1_data_i;
    w_rs2_val = (w_rs2 == 5'd0) ? '0 : rs2_data_i;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (w_hit1[k]) w_rs1_val = w_fwd_data[k];
      if (w_hit2[k]) w_rs2_val = w_fwd_data[k];
    end
  end
`else
  assign w_hazard  = |((w_hit1 & {NFWD{w_use1}}) | (w_hit2 & {NFWD{w_use2}}));
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : rs1_data_i;
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : rs2_data_i;

  logic w_unused;
  assign w_unused = &{1'b0, ex_load_i, fwd_wdata_i};
`endif

  // Handshake and slot update
  slot_t slot_q, slot_d, w_new;
  logic  w_upd, w_accept, w_stall_ev;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  assign w_upd      = ~slot_q.valid | ex_ready_i;
  assign if_ready_o = flush_i | (~w_hazard & w_upd);
  assign w_accept   = if_valid_i & if_ready_o & ~flush_i;
  assign w_stall_ev = if_valid_i & w_hazard & ~flush_i;

  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.cls     = w_cls;
    w_new.fn      = w_fn;
    w_new.imm     = w_imm;
    w_new.pc      = pc_i;
    w_new.wd      = w_rd;
    w_new.wreg    = w_wr & (w_rd != 5'd0);
    w_new.illegal = w_illegal;
    w_new.b       = w_b_rs2 ? w_rs2_val : w_imm;
    case (w_asel)
      c_ASEL_RS1: w_new.a = w_rs1_val;
      c_ASEL_PC:  w_new.a = pc_i;
      default:    w_new.a = '0;
    endcase
  end

  // Flush wins over hold; a stage update without an accepted instruction
  // (hazard or idle fetch) loads an all-zero bubble
  always_comb begin
    slot_d = slot_q;
    if (flush_i)    slot_d = '0;
    else if (w_upd) slot_d = w_accept ? w_new : '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (w_stall_ev && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid_o   = slot_q.valid;
  assign ex_cls_o     = slot_q.cls;
  assign ex_fn_o      = slot_q.fn;
  assign ex_a_o       = slot_q.a;
  assign ex_b_o       = slot_q.b;
  assign ex_imm_o     = slot_q.imm;
  assign ex_pc_o      = slot_q.pc;
  assign ex_wd_o      = slot_q.wd;
  assign ex_wreg_o    = slot_q.wreg;
  assign ex_illegal_o = slot_q.illegal;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
`default_nettype wire
